// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds FSM states, default latencies and register-index type.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;

  localparam int MD_CNT_W = 6;

  typedef logic [4:0] reg_idx_t;

  typedef logic [MD_CNT_W-1:0] md_cnt_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_timer.sv
// Multiply/divide occupancy timer.
// Counts the remaining busy cycles and pulses done on the way out.
module md_occupancy_timer
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_i,
  input  md_cnt_t load_val_i,
  input  logic    busy_i,
  output logic    cnt_zero_o,
  output logic    md_done_o
);

  md_cnt_t md_cnt_q, md_cnt_d;
  logic    md_done_q, md_done_d;

  assign cnt_zero_o = (md_cnt_q == '0);

  // Next count: reload on accept, otherwise walk down while busy.
  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    if (load_i) begin
      md_cnt_d = load_val_i;
    end else if (busy_i) begin
      if (cnt_zero_o) begin
        md_done_d = 1'b1;
      end else begin
        md_cnt_d = md_cnt_q - 1'b1;
      end
    end
  end

  // Counter and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q  <= '0;
      md_done_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
    end
  end

  assign md_done_o = md_done_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use, HI/LO and branch control.
// Owns the RUN/MD_BUSY FSM and the stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  reg_idx_t    id_rs,
  input  reg_idx_t    id_rt,
  input  logic        id_uses_rt,
  input  logic        id_ex_memread,
  input  reg_idx_t    id_ex_rt,
  input  logic        ex_branch_taken,
  input  logic        id_md_start,
  input  logic        id_md_is_div,
  input  logic        id_reads_hilo,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  localparam md_cnt_t MULT_M1 = md_cnt_t'(MULT_LAT - 1);
  localparam md_cnt_t DIV_M1  = md_cnt_t'(DIV_LAT - 1);

  hz_state_e   state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic    load_use;
  logic    md_hazard;
  logic    stall;
  logic    md_accept;
  logic    cnt_zero;
  md_cnt_t md_load_val;

  assign load_use = id_ex_memread
                 && (id_ex_rt != '0)
                 && ((id_ex_rt == id_rs)
                  || (id_uses_rt && (id_ex_rt == id_rt)));

  assign md_hazard = (state_q == MD_BUSY)
                  && (id_reads_hilo || id_md_start);

  assign stall = (load_use || md_hazard) && !ex_branch_taken;

  assign md_accept = (state_q == RUN) && id_md_start
                  && !ex_branch_taken && !load_use;

  assign md_load_val = id_md_is_div ? DIV_M1 : MULT_M1;

  assign pc_write     = rst_n && !stall;
  assign if_id_write  = rst_n && !stall;
  assign id_ex_bubble = !rst_n || stall || ex_branch_taken;
  assign if_id_flush  = !rst_n || ex_branch_taken;

  assign md_busy = (state_q == MD_BUSY);

  md_occupancy_timer u_md_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (md_accept),
    .load_val_i (md_load_val),
    .busy_i     (md_busy),
    .cnt_zero_o (cnt_zero),
    .md_done_o  (md_done)
  );

  // FSM next state: enter on an accepted start, leave at count zero.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (md_accept) state_d = MD_BUSY;
      end
      MD_BUSY: begin
        if (cnt_zero) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating count of stall cycles; branch squashes are not stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
